// File: rtl/uop_sequencer_pkg.sv
// ============================================================================
// Module      : uop_sequencer_pkg
// Description : Shared CPU constants for the micro-op sequencer and microcode ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uop_sequencer_pkg;

    localparam int UOP_W = 3;
    localparam int CNT_W = 16;

    // The all-ones code is reserved: the ROM treats it as "no instruction".
    localparam logic [UOP_W-1:0] IDLE_UOP  = '1;
    localparam logic [UOP_W-1:0] UOP_FETCH = '0;

    typedef enum logic [1:0] {
        SEQ_HALTED = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_STEP   = 2'd2
    } seq_state_t;

endpackage : uop_sequencer_pkg

`default_nettype wire

// File: rtl/uop_sequencer_if.sv
// ============================================================================
// Module      : uop_sequencer_if
// Description : Host/ROM-facing signal bundle of the sequencer; INSTR_CNT only
//               exists when SEQ_INSTR_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uop_sequencer_if;
    import uop_sequencer_pkg::*;

    logic             RUN;
    logic             STEP;
    logic             HALT_REQ;
    logic             RESET_uOP;
    logic             READ_FLAGS;
    logic             ALU_ZERO;
    logic             ALU_COUT;
    logic [UOP_W-1:0] uOP;
    logic             ZERO_FLAG;
    logic             COUT_FLAG;
    logic             HALTED;
    logic             INSTR_DONE;
    logic             ILLEGAL;
`ifdef SEQ_INSTR_CNT_EN
    logic [CNT_W-1:0] INSTR_CNT;

    modport master (
        input  RUN, STEP, HALT_REQ, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
        output uOP, ZERO_FLAG, COUT_FLAG, HALTED, INSTR_DONE, ILLEGAL, INSTR_CNT
    );
    modport slave (
        output RUN, STEP, HALT_REQ, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
        input  uOP, ZERO_FLAG, COUT_FLAG, HALTED, INSTR_DONE, ILLEGAL, INSTR_CNT
    );
`else
    modport master (
        input  RUN, STEP, HALT_REQ, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
        output uOP, ZERO_FLAG, COUT_FLAG, HALTED, INSTR_DONE, ILLEGAL
    );
    modport slave (
        output RUN, STEP, HALT_REQ, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
        input  uOP, ZERO_FLAG, COUT_FLAG, HALTED, INSTR_DONE, ILLEGAL
    );
`endif

endinterface : uop_sequencer_if

`default_nettype wire

// File: rtl/uop_sequencer.sv
// ============================================================================
// Module      : uop_sequencer
// Description : Micro-step counter, flag register and run/halt/step control
//               with runaway watchdog. Define SEQ_INSTR_CNT_EN for INSTR_CNT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uop_sequencer
    import uop_sequencer_pkg::*;
(
    input  wire logic       CLK,
    input  wire logic       RST,
    uop_sequencer_if.master seq_if
);

    localparam logic [UOP_W-1:0] c_wdog_uop = IDLE_UOP - 1'b1;

    seq_state_t       r_state;
    logic [UOP_W-1:0] r_uop;
    logic             r_zero;
    logic             r_cout;
    logic             r_halted;
    logic             r_done;
    logic             r_illegal;
    logic             w_wdog;
    logic             w_stop;

    // A step that would reach the idle code is a runaway instruction.
    assign w_wdog = (r_uop == c_wdog_uop) && !seq_if.RESET_uOP;
    assign w_stop = (r_state == SEQ_STEP) || seq_if.HALT_REQ || !seq_if.RUN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= SEQ_HALTED;
            r_uop     <= IDLE_UOP;
            r_zero    <= 1'b0;
            r_cout    <= 1'b0;
            r_halted  <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SEQ_HALTED: begin
                    if (!seq_if.HALT_REQ && seq_if.RUN) begin
                        r_state  <= SEQ_RUN;
                        r_uop    <= UOP_FETCH;
                        r_halted <= 1'b0;
                    end else if (!seq_if.HALT_REQ && seq_if.STEP) begin
                        r_state  <= SEQ_STEP;
                        r_uop    <= UOP_FETCH;
                        r_halted <= 1'b0;
                    end
                end
                SEQ_RUN, SEQ_STEP: begin
                    if (seq_if.READ_FLAGS) begin
                        r_zero <= seq_if.ALU_ZERO;
                        r_cout <= seq_if.ALU_COUT;
                    end
                    if (seq_if.RESET_uOP || w_wdog) begin
                        // An abort obeys the same halt rules as a retirement.
                        r_done <= seq_if.RESET_uOP;
                        if (w_wdog) begin
                            r_illegal <= 1'b1;
                        end
                        if (w_stop) begin
                            r_state  <= SEQ_HALTED;
                            r_uop    <= IDLE_UOP;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= SEQ_RUN;
                            r_uop   <= UOP_FETCH;
                        end
                    end else begin
                        r_uop <= r_uop + 1'b1;
                    end
                end
                default: begin
                    r_state  <= SEQ_HALTED;
                    r_uop    <= IDLE_UOP;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_INSTR_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if ((r_state != SEQ_HALTED) && seq_if.RESET_uOP) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign seq_if.INSTR_CNT = r_cnt;
`endif

    assign seq_if.uOP        = r_uop;
    assign seq_if.ZERO_FLAG  = r_zero;
    assign seq_if.COUT_FLAG  = r_cout;
    assign seq_if.HALTED     = r_halted;
    assign seq_if.INSTR_DONE = r_done;
    assign seq_if.ILLEGAL    = r_illegal;

endmodule : uop_sequencer

`default_nettype wire

// File: tb/tb_uop_sequencer.sv
// ============================================================================
// Module      : tb_uop_sequencer
// Description : Directed scenarios plus randomized run against a behavioural
//               model of the sequencer; INSTR_CNT checked with SEQ_INSTR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uop_sequencer;
    import uop_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uop_sequencer_if sif ();

    uop_sequencer dut (
        .CLK    (clk),
        .RST    (rst),
        .seq_if (sif)
    );

    int errors = 0;
    int checks = 0;
    int rom_last = 7;   // uOP at which the ROM model strobes RESET_uOP; <0 = random

    // Behavioural model: "busy" executing an instruction or idle.
    bit m_busy   = 1'b0;
    bit m_single = 1'b0;
    int m_uop    = 7;
    bit m_zero   = 1'b0;
    bit m_cout   = 1'b0;
    bit m_done   = 1'b0;
    bit m_ill    = 1'b0;
    int m_cnt    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_single <= 1'b0; m_uop <= 7; m_zero <= 1'b0;
            m_cout <= 1'b0; m_done <= 1'b0; m_ill <= 1'b0; m_cnt <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (!sif.HALT_REQ && (sif.RUN || sif.STEP)) begin
                m_busy <= 1'b1; m_single <= !sif.RUN; m_uop <= 0;
            end
        end else begin
            m_done <= 1'b0;
            if (sif.READ_FLAGS) begin
                m_zero <= sif.ALU_ZERO; m_cout <= sif.ALU_COUT;
            end
            if (sif.RESET_uOP || m_uop == 6) begin
                if (sif.RESET_uOP) begin
                    m_done <= 1'b1; m_cnt <= (m_cnt + 1) % 65536;
                end else begin
                    m_ill <= 1'b1;
                end
                if (m_single || sif.HALT_REQ || !sif.RUN) begin
                    m_busy <= 1'b0; m_uop <= 7;
                end else begin
                    m_uop <= 0;
                end
            end else begin
                m_uop <= m_uop + 1;
            end
        end
    end

    // ROM model drives RESET_uOP, then one clock edge passes.
    task automatic tick();
        if (rom_last < 0) sif.RESET_uOP = ($urandom_range(0, 3) == 0);
        else              sif.RESET_uOP = m_busy && (m_uop == rom_last);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.RUN = 0; sif.STEP = 0; sif.HALT_REQ = 0; sif.READ_FLAGS = 0;
        sif.ALU_ZERO = 0; sif.ALU_COUT = 0; sif.RESET_uOP = 0;
        rom_last = 7;
        tick(); tick();
        rst = 1'b0;
        checks++; if (sif.uOP !== 3'd7) begin errors++; $display("FAIL reset_uop: got %0d want 7", sif.uOP); end
        checks++; if (sif.HALTED !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b want 1", sif.HALTED); end
        checks++; if ({sif.ZERO_FLAG, sif.COUT_FLAG} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b want 00", sif.ZERO_FLAG, sif.COUT_FLAG); end
        checks++; if ({sif.INSTR_DONE, sif.ILLEGAL} !== 2'b00) begin errors++; $display("FAIL reset_done_ill: got %b%b want 00", sif.INSTR_DONE, sif.ILLEGAL); end
`ifdef SEQ_INSTR_CNT_EN
        checks++; if (sif.INSTR_CNT !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", sif.INSTR_CNT); end
`endif
        tick();
        checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1) begin errors++; $display("FAIL idle_hold: got uop=%0d halted=%b want 7/1", sif.uOP, sif.HALTED); end
    endtask

    task automatic test_run();
        int  exp_uop [7] = '{0, 1, 2, 0, 1, 2, 0};
        bit  exp_done[7] = '{0, 0, 0, 1, 0, 0, 1};
        rom_last = 2;
        sif.RUN = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (sif.uOP !== 3'(exp_uop[i]) || sif.INSTR_DONE !== exp_done[i] || sif.HALTED !== 1'b0) begin
                errors++; $display("FAIL run_seq[%0d]: got uop=%0d done=%b halted=%b want %0d/%b/0", i, sif.uOP, sif.INSTR_DONE, sif.HALTED, exp_uop[i], exp_done[i]);
            end
        end
`ifdef SEQ_INSTR_CNT_EN
        checks++; if (sif.INSTR_CNT !== 16'd2) begin errors++; $display("FAIL run_cnt: got %0d want 2", sif.INSTR_CNT); end
`endif
        sif.RUN = 0;
        tick(); tick();
        checks++; if (sif.uOP !== 3'd2 || sif.HALTED !== 1'b0) begin errors++; $display("FAIL run_drop_mid: got uop=%0d halted=%b want 2/0", sif.uOP, sif.HALTED); end
        tick();
        checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1 || sif.INSTR_DONE !== 1'b1) begin
            errors++; $display("FAIL run_halt: got uop=%0d halted=%b done=%b want 7/1/1", sif.uOP, sif.HALTED, sif.INSTR_DONE);
        end
    endtask

    task automatic test_step();
        rom_last = 5;
        for (int rep = 0; rep < 2; rep++) begin
            sif.STEP = 1;
            tick();
            sif.STEP = 0;
            checks++; if (sif.uOP !== 3'd0 || sif.HALTED !== 1'b0) begin errors++; $display("FAIL step_start[%0d]: got uop=%0d halted=%b want 0/0", rep, sif.uOP, sif.HALTED); end
            for (int i = 1; i <= 5; i++) begin
                sif.STEP = (i == 3);
                tick();
                checks++; if (sif.uOP !== 3'(i) || sif.INSTR_DONE !== 1'b0) begin
                    errors++; $display("FAIL step_seq[%0d.%0d]: got uop=%0d done=%b want %0d/0", rep, i, sif.uOP, sif.INSTR_DONE, i);
                end
            end
            sif.STEP = 0;
            tick();
            checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1 || sif.INSTR_DONE !== 1'b1) begin
                errors++; $display("FAIL step_end[%0d]: got uop=%0d halted=%b done=%b want 7/1/1", rep, sif.uOP, sif.HALTED, sif.INSTR_DONE);
            end
            tick();
            checks++; if (sif.uOP !== 3'd7 || sif.INSTR_DONE !== 1'b0) begin errors++; $display("FAIL step_once[%0d]: got uop=%0d done=%b want 7/0", rep, sif.uOP, sif.INSTR_DONE); end
        end
    endtask

    task automatic test_halt_req();
        rom_last = 3;
        sif.RUN = 1;
        tick(); tick();
        sif.HALT_REQ = 1;
        tick();
        checks++; if (sif.uOP !== 3'd2 || sif.HALTED !== 1'b0) begin errors++; $display("FAIL hreq_mid: got uop=%0d halted=%b want 2/0", sif.uOP, sif.HALTED); end
        tick();
        checks++; if (sif.uOP !== 3'd3) begin errors++; $display("FAIL hreq_last: got uop=%0d want 3", sif.uOP); end
        tick();
        checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1 || sif.INSTR_DONE !== 1'b1) begin
            errors++; $display("FAIL hreq_halt: got uop=%0d halted=%b done=%b want 7/1/1", sif.uOP, sif.HALTED, sif.INSTR_DONE);
        end
        tick();
        checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1) begin errors++; $display("FAIL hreq_override: got uop=%0d halted=%b want 7/1", sif.uOP, sif.HALTED); end
        sif.HALT_REQ = 0; sif.RUN = 0;
        tick();
    endtask

    task automatic test_watchdog();
        rom_last = 7;
        sif.RUN = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (sif.uOP !== 3'(i) || sif.ILLEGAL !== 1'b0 || sif.INSTR_DONE !== 1'b0) begin
                errors++; $display("FAIL wdog_seq[%0d]: got uop=%0d ill=%b done=%b want %0d/0/0", i, sif.uOP, sif.ILLEGAL, sif.INSTR_DONE, i);
            end
        end
        tick();
        checks++; if (sif.uOP !== 3'd0 || sif.ILLEGAL !== 1'b1 || sif.INSTR_DONE !== 1'b0) begin
            errors++; $display("FAIL wdog_fire: got uop=%0d ill=%b done=%b want 0/1/0", sif.uOP, sif.ILLEGAL, sif.INSTR_DONE);
        end
        sif.RUN = 0;
        repeat (7) tick();
        checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1 || sif.ILLEGAL !== 1'b1 || sif.INSTR_DONE !== 1'b0) begin
            errors++; $display("FAIL wdog_halt: got uop=%0d halted=%b ill=%b done=%b want 7/1/1/0", sif.uOP, sif.HALTED, sif.ILLEGAL, sif.INSTR_DONE);
        end
`ifdef SEQ_INSTR_CNT_EN
        checks++; if (sif.INSTR_CNT !== 16'd6) begin errors++; $display("FAIL wdog_cnt: got %0d want 6", sif.INSTR_CNT); end
`endif
    endtask

    task automatic test_flags();
        rom_last = 1;
        sif.STEP = 1;
        tick();
        sif.STEP = 0; sif.READ_FLAGS = 1; sif.ALU_ZERO = 1; sif.ALU_COUT = 0;
        tick();
        checks++; if ({sif.ZERO_FLAG, sif.COUT_FLAG} !== 2'b10) begin errors++; $display("FAIL flags_latch: got %b%b want 10", sif.ZERO_FLAG, sif.COUT_FLAG); end
        sif.READ_FLAGS = 0; sif.ALU_ZERO = 0; sif.ALU_COUT = 1;
        tick();
        sif.READ_FLAGS = 1;
        repeat (3) tick();
        checks++; if ({sif.ZERO_FLAG, sif.COUT_FLAG} !== 2'b10 || sif.HALTED !== 1'b1) begin
            errors++; $display("FAIL flags_hold: got %b%b halted=%b want 10/1", sif.ZERO_FLAG, sif.COUT_FLAG, sif.HALTED);
        end
        sif.STEP = 1;
        tick();
        sif.STEP = 0;
        tick();
        sif.READ_FLAGS = 0;
        checks++; if ({sif.ZERO_FLAG, sif.COUT_FLAG} !== 2'b01) begin errors++; $display("FAIL flags_cout: got %b%b want 01", sif.ZERO_FLAG, sif.COUT_FLAG); end
        tick();
    endtask

    task automatic test_reset_mid();
        rom_last = 4;
        sif.RUN = 1;
        repeat (4) tick();
        checks++; if (sif.uOP !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got uop=%0d want 3", sif.uOP); end
        rst = 1;
        tick();
        rst = 0; sif.RUN = 0;
        checks++; if (sif.uOP !== 3'd7 || sif.HALTED !== 1'b1 || {sif.ZERO_FLAG, sif.COUT_FLAG, sif.ILLEGAL} !== 3'b000) begin
            errors++; $display("FAIL rstmid: got uop=%0d halted=%b z=%b c=%b ill=%b want 7/1/0/0/0", sif.uOP, sif.HALTED, sif.ZERO_FLAG, sif.COUT_FLAG, sif.ILLEGAL);
        end
`ifdef SEQ_INSTR_CNT_EN
        checks++; if (sif.INSTR_CNT !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", sif.INSTR_CNT); end
`endif
    endtask

    task automatic test_random();
        rom_last = -1;
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 249) == 0);
            sif.RUN        = ($urandom_range(0, 9) != 0);
            sif.STEP       = ($urandom_range(0, 4) == 0);
            sif.HALT_REQ   = ($urandom_range(0, 7) == 0);
            sif.READ_FLAGS = 1'($urandom_range(0, 1));
            sif.ALU_ZERO   = 1'($urandom_range(0, 1));
            sif.ALU_COUT   = 1'($urandom_range(0, 1));
            tick();
            checks++; if (sif.uOP !== 3'(m_uop) || sif.HALTED !== !m_busy || sif.INSTR_DONE !== m_done || sif.ILLEGAL !== m_ill) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got uop=%0d halted=%b done=%b ill=%b want %0d/%b/%b/%b", n, sif.uOP, sif.HALTED, sif.INSTR_DONE, sif.ILLEGAL, m_uop, !m_busy, m_done, m_ill);
            end
            checks++; if (sif.ZERO_FLAG !== m_zero || sif.COUT_FLAG !== m_cout) begin
                errors++; $display("FAIL rand_flags[%0d]: got %b%b want %b%b", n, sif.ZERO_FLAG, sif.COUT_FLAG, m_zero, m_cout);
            end
`ifdef SEQ_INSTR_CNT_EN
            checks++; if (sif.INSTR_CNT !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, sif.INSTR_CNT, m_cnt); end
`endif
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_halt_req();
        test_watchdog();
        test_flags();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uop_sequencer

`default_nettype wire

// File: doc/uop_sequencer.md
# uop_sequencer

Micro-operation sequencer that drives the `uOP` step input of the controller microcode ROM and holds the CPU flag register. It advances `uOP` each clock, restarts it on the ROM's `RESET_uOP` strobe, and latches ALU flags on `READ_FLAGS`. It also provides run/halt/single-step control at instruction boundaries, a watchdog for runaway micro-sequences and an optional retired-instruction counter. It sits between the front-panel/host control inputs and the ROM, in the CPU core beside the IR.

## Interface
- `UOP_W`, 3, width of the micro-step counter; `IDLE_UOP` = 2^UOP_W−1 is reserved as the idle/reset code.
- `CNT_W`, 16, width of the retired-instruction counter (only with `SEQ_INSTR_CNT_EN`).

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RUN`  in  1  level; 1 = free-run, 0 = halt at the next instruction boundary.
- `STEP`  in  1  single-cycle pulse; in HALTED, executes exactly one instruction.
- `HALT_REQ`  in  1  level; forces a halt at the next boundary and overrides `RUN`.
- `RESET_uOP`  in  1  from ROM; the current step is the last step of the instruction.
- `READ_FLAGS`  in  1  from ROM; latch ALU flags this cycle.
- `ALU_ZERO`  in  1  ALU zero result.
- `ALU_COUT`  in  1  ALU carry out.
- `uOP`  out  UOP_W  registered micro-step to the ROM.
- `ZERO_FLAG`  out  1  registered zero flag to the ROM.
- `COUT_FLAG`  out  1  registered carry flag to the ROM.
- `HALTED`  out  1  1 while in HALTED.
- `INSTR_DONE`  out  1  one-cycle pulse after each retired instruction.
- `ILLEGAL`  out  1  sticky; set by the watchdog, cleared only by `RST`.
- `INSTR_CNT`  out  CNT_W  retired-instruction count (only with `SEQ_INSTR_CNT_EN`).

## Operation
- States:
  - HALTED: `uOP` = `IDLE_UOP`.
  - RUN: free-running execution.
  - STEP: RUN for one instruction only.
- Reset values:
  - State = HALTED.
  - `uOP` = `IDLE_UOP`.
  - `ZERO_FLAG`, `COUT_FLAG`, `INSTR_DONE`, `ILLEGAL` = 0.
  - `HALTED` = 1.
  - `INSTR_CNT` = 0.
- HALTED, with `RUN`=1 and `HALT_REQ`=0:
  - Next state is RUN; `uOP` becomes 0.
  - `RUN` takes priority over a simultaneous `STEP`.
- HALTED, with `STEP`=1, `RUN`=0 and `HALT_REQ`=0:
  - Next state is STEP; `uOP` becomes 0.
- In HALTED, the ROM's `RESET_uOP` and `READ_FLAGS` are ignored.
- RUN/STEP, with `RESET_uOP`=1 (instruction boundary):
  - Retire the instruction: `INSTR_DONE` is 1 the next cycle, and `INSTR_CNT` increments.
  - Go to HALTED (`uOP` = `IDLE_UOP`) if any of these holds: the state is STEP, `HALT_REQ`=1, or `RUN`=0.
  - Otherwise stay in RUN with `uOP` = 0.
- RUN/STEP, with `RESET_uOP`=0:
  - `uOP` increments by 1.
- Watchdog:
  - Fires when `uOP` = `IDLE_UOP`−1 and `RESET_uOP`=0.
  - Response: `ILLEGAL` is set, the instruction is aborted and `uOP` becomes 0.
  - The abort follows the boundary rules above (may halt), but does not pulse `INSTR_DONE` and does not count.
  - Consequence: `IDLE_UOP` is never reached while executing.
- Flags: in RUN/STEP, when `READ_FLAGS`=1, `ZERO_FLAG` ← `ALU_ZERO` and `COUT_FLAG` ← `ALU_COUT`. Otherwise the flags hold, including across halts.
- `HALT_REQ` or a `RUN` drop mid-instruction never truncates the instruction; it takes effect only at the boundary.
- `STEP` pulses received while in RUN or STEP are ignored.
- `INSTR_CNT` wraps modulo 2^CNT_W.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Start latency: `RUN` high at edge N → `uOP`=0 after edge N; `HALTED`=0 in the same cycle.
- Step: `STEP` sampled at edge N → `uOP` 0,1,…,k over the instruction's k+1 cycles. `RESET_uOP` sampled at uOP k → `HALTED`=1, `uOP`=`IDLE_UOP` and `INSTR_DONE`=1 after the next edge.
- Back-to-back instructions: `uOP` goes k→0 with zero bubble cycles.
- A flag update is visible to the ROM on the cycle after `READ_FLAGS`, so a branch in the next instruction sees it.
- `RST` asserted mid-instruction: the next edge gives the reset values regardless of state.

## Configuration
- `SEQ_INSTR_CNT_EN` defined: `INSTR_CNT` port and the CNT_W-bit counter are present, behaving as above.
- `SEQ_INSTR_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared CPU package holds:
  - The state encoding (`SEQ_HALTED`, `SEQ_RUN`, `SEQ_STEP`).
  - `UOP_W`, and the `IDLE_UOP` and `UOP_FETCH`=0 constants, shared with the microcode ROM.
- A single module; no sub-module needed. The optional counter is an inline guarded block.

## Test plan
- Reset, then `RUN`=1 with the ROM model returning `RESET_uOP` at uOP 2 → `uOP` sequence 7,0,1,2,0,1,2; `INSTR_DONE` pulses every 3 cycles; `INSTR_CNT` = 2 after two instructions.
- Halted with a `STEP` pulse, instruction ending at uOP 5 → `uOP` 0..5, then 7; `HALTED`=1; exactly one `INSTR_DONE`; a second `STEP` repeats the same behaviour.
- `HALT_REQ` raised at uOP 1 of a 4-step instruction → `uOP` reaches 3, then 7; `HALTED` asserted; no truncation.
- ROM model never asserts `RESET_uOP` → `uOP` 0..6, then 0; `ILLEGAL`=1 and sticky; `INSTR_DONE` stays 0; `INSTR_CNT` unchanged.
- `READ_FLAGS`=1 with `ALU_ZERO`=1, `ALU_COUT`=0, then halt → `ZERO_FLAG`=1, `COUT_FLAG`=0, held through HALTED. `READ_FLAGS` pulsed while HALTED → no change.
- `RST` asserted at uOP 3 in RUN → next cycle: `uOP`=7, `HALTED`=1, flags 0, `ILLEGAL` 0, `INSTR_CNT` 0.
